// File: rtl/y_packer.sv
// y_packer: gathers 4-bit nibbles from the upstream xpto stage into 16-bit words
// (first nibble in w[3:0]) and buffers completed words in a small FIFO with a
// valid/ready output handshake.
//
// Configuration macro: Y_PACKER_SUM_EN
//   defined   - each word carries the 6-bit sum of its nibbles, driven on w_sum.
//   undefined - no sum logic or storage; w_sum is tied to 0.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   y[3:0]     in   nibble from upstream
//   y_is_valid in   y valid this cycle, accepted unconditionally
//   w[15:0]    out  packed word at FIFO head (0 while FIFO empty)
//   w_sum[5:0] out  sum of the four nibbles of w
//   w_valid    out  FIFO non-empty
//   w_ready    in   downstream accepts; transfer on w_valid && w_ready
//   overflow   out  sticky: a completed word was dropped (cleared only by rst)
//
// FIFO_DEPTH must be a power of two >= 2 so the pointers wrap naturally.

module y_packer #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  y,
  input  logic        y_is_valid,
  output logic [15:0] w,
  output logic [5:0]  w_sum,
  output logic        w_valid,
  input  logic        w_ready,
  output logic        overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] PtrOne  = AW'(1);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  // ---------------------------------------------------------------------------
  // Nibble collector
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {StC0, StC1, StC2, StC3} col_state_e;

  col_state_e  state_q, state_d;
  // Only the first three nibbles need storage: the fourth arrives together with
  // the push and is taken straight from y.
  logic [11:0] nib_q, nib_d;
  logic        word_done;
  logic [15:0] new_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StC0;
      nib_q   <= '0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    nib_d     = nib_q;
    word_done = 1'b0;
    if (y_is_valid) begin
      unique case (state_q)
        StC0: begin
          nib_d[3:0] = y;
          state_d    = StC1;
        end
        StC1: begin
          nib_d[7:4] = y;
          state_d    = StC2;
        end
        StC2: begin
          nib_d[11:8] = y;
          state_d     = StC3;
        end
        StC3: begin
          word_done = 1'b1;
          state_d   = StC0;
        end
        default: state_d = StC0;
      endcase
    end
  end

  assign new_word = {y, nib_q};

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [15:0]   word_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          fifo_full, fifo_empty;
  logic          pop, push_ok;

  assign fifo_full  = (count_q == FullCnt);
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && w_ready;
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign push_ok    = word_done && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
    if (word_done && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; the output mux hides stale entries while empty.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      word_mem[wr_ptr_q] <= new_word;
    end
  end

  assign w_valid  = !fifo_empty;
  assign w        = fifo_empty ? 16'h0000 : word_mem[rd_ptr_q];
  assign overflow = overflow_q;

  // ---------------------------------------------------------------------------
  // Optional per-word nibble sum
  // ---------------------------------------------------------------------------
`ifdef Y_PACKER_SUM_EN
  logic [5:0] sum_mem [FIFO_DEPTH];
  logic [5:0] new_sum;

  assign new_sum = {2'b00, nib_q[3:0]} + {2'b00, nib_q[7:4]} +
                   {2'b00, nib_q[11:8]} + {2'b00, y};

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      sum_mem[wr_ptr_q] <= new_sum;
    end
  end

  assign w_sum = fifo_empty ? 6'd0 : sum_mem[rd_ptr_q];
`else
  assign w_sum = 6'd0;
`endif

endmodule

// File: tb/tb_y_packer.sv
// Bench for y_packer: directed scenarios followed by randomized traffic, all
// checked cycle by cycle against a queue-based reference model.

module tb_y_packer;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic [3:0]  y;
  logic        y_is_valid;
  logic [15:0] w;
  logic [5:0]  w_sum;
  logic        w_valid;
  logic        w_ready;
  logic        overflow;

  int n_vec;
  int n_err;

  // Reference model state
  int part[$];
  int fifo[$];
  bit ovf_m;

  y_packer #(
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .y         (y),
    .y_is_valid(y_is_valid),
    .w         (w),
    .w_sum     (w_sum),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_sum(input int word);
`ifdef Y_PACKER_SUM_EN
    return (word & 15) + ((word >> 4) & 15) + ((word >> 8) & 15) + ((word >> 12) & 15);
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare all outputs against the model.
  task automatic check_outputs();
    chk("w_valid", {31'd0, w_valid}, {31'd0, fifo.size() != 0});
    chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
    if (fifo.size() != 0) begin
      chk("w", {16'd0, w}, fifo[0]);
      chk("w_sum", {26'd0, w_sum}, exp_sum(fifo[0]));
    end
  endtask

  // One clock cycle: drive inputs, advance the model across the edge, check.
  task automatic step(input logic [3:0] yv, input logic v, input logic rdy, input logic r);
    int  pre;
    bit  pop;
    int  word;
    y          = yv;
    y_is_valid = v;
    w_ready    = rdy;
    rst        = r;
    @(posedge clk);
    if (r) begin
      part.delete();
      fifo.delete();
      ovf_m = 1'b0;
    end else begin
      pre = fifo.size();
      pop = (pre != 0) && rdy;
      if (pop) void'(fifo.pop_front());
      if (v) begin
        part.push_back(int'(yv));
        if (part.size() == 4) begin
          word = part[0] + part[1] * 16 + part[2] * 256 + part[3] * 4096;
          part.delete();
          if (pre < DEPTH || pop) fifo.push_back(word);
          else ovf_m = 1'b1;
        end
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    step(4'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_w", {16'd0, w}, 32'd0);
    chk("rst_w_sum", {26'd0, w_sum}, 32'd0);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    ovf_m      = 1'b0;
    rst        = 1'b1;
    y          = '0;
    y_is_valid = 1'b0;
    w_ready    = 1'b0;

    // Reset with valid data presented: must be ignored.
    step(4'h7, 1'b1, 1'b1, 1'b1);
    do_reset();

    // Four 5s, downstream ready.
    for (int i = 0; i < 4; i++) step(4'h5, 1'b1, 1'b1, 1'b0);
    chk("r29_w", {16'd0, w}, 32'h5555);
    chk("r29_valid", {31'd0, w_valid}, 32'd1);
    step(4'h0, 1'b0, 1'b1, 1'b0);
    chk("r29_one_cycle", {31'd0, w_valid}, 32'd0);

    // Nibbles 1..4 separated by two idle cycles.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step(4'(i), 1'b1, 1'b1, 1'b0);
      if (i < 4) begin
        step(4'h0, 1'b0, 1'b1, 1'b0);
        step(4'h0, 1'b0, 1'b1, 1'b0);
      end
    end
    chk("r30_w", {16'd0, w}, 32'h4321);
    step(4'h0, 1'b0, 1'b1, 1'b0);

    // Stalled downstream: third word dropped.
    do_reset();
    for (int i = 1; i <= 12; i++) step(4'(i), 1'b1, 1'b0, 1'b0);
    chk("r31_ovf", {31'd0, overflow}, 32'd1);
    chk("r31_head", {16'd0, w}, 32'h4321);
    step(4'h0, 1'b0, 1'b1, 1'b0);
    chk("r31_second", {16'd0, w}, 32'h8765);
    for (int i = 0; i < 3; i++) step(4'h0, 1'b0, 1'b1, 1'b0);
    chk("r31_sticky", {31'd0, overflow}, 32'd1);

    // Full FIFO popped in the same cycle as the third word completes.
    do_reset();
    for (int i = 1; i <= 11; i++) step(4'(i), 1'b1, 1'b0, 1'b0);
    step(4'hC, 1'b1, 1'b1, 1'b0);
    chk("r32_ovf", {31'd0, overflow}, 32'd0);
    chk("r32_head", {16'd0, w}, 32'h8765);
    for (int i = 0; i < 3; i++) step(4'h0, 1'b0, 1'b1, 1'b0);

    // Partial word discarded by reset.
    do_reset();
    step(4'h3, 1'b1, 1'b1, 1'b0);
    step(4'h3, 1'b1, 1'b1, 1'b0);
    step(4'h3, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(4'hF, 1'b1, 1'b1, 1'b0);
    chk("r33_w", {16'd0, w}, 32'hFFFF);
    step(4'h0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic with varying downstream readiness.
    do_reset();
    for (int blk = 0; blk < 8; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(0, 100);
      for (int i = 0; i < 100; i++) begin
        step(4'($urandom_range(0, 15)),
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 99) < rdy_pct,
             $urandom_range(0, 149) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/y_packer.md
Y_PACKER -- requirements
Module: y_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, number of completed words buffered; SHALL be a power of two >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 y  input  4  nibble from the upstream xpto stage.
REQ-005 y_is_valid  input  1  y is valid this cycle; SHALL be accepted unconditionally (upstream has no backpressure).
REQ-006 w  output  16  packed word at FIFO head.
REQ-007 w_sum  output  6  sum of the four nibbles of w.
REQ-008 w_valid  output  1  w/w_sum valid (FIFO non-empty).
REQ-009 w_ready  input  1  downstream accepts; transfer occurs when w_valid && w_ready.
REQ-010 overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-011 Collector SHALL be a 2-bit nibble counter, states C0..C3; each cycle with y_is_valid=1 stores y into slot [count] and advances C0->C1->C2->C3->C0.
REQ-012 Cycles with y_is_valid=0 SHALL leave counter and stored nibbles unchanged (gaps of any length allowed).
REQ-013 Packing order SHALL be little-endian: first nibble -> w[3:0], fourth -> w[15:12].
REQ-014 Word completes in the cycle y_is_valid=1 in C3; complete word SHALL be pushed into FIFO at that same edge, giving w_valid=1 in the next cycle when the FIFO was empty (latency 1 cycle from 4th nibble).
REQ-015 w_sum SHALL be the unsigned 6-bit sum of the four nibbles (max 60, no overflow), computed before the push and stored alongside w.
REQ-016 w_valid SHALL equal FIFO non-empty; w/w_sum SHALL be held stable while w_valid=1 and w_ready=0.
REQ-017 Pop SHALL occur on w_valid && w_ready; words SHALL leave in push order.
REQ-018 Push when FIFO full and no pop same cycle: word SHALL be dropped, FIFO contents unchanged, overflow set to 1.
REQ-019 Push when FIFO full with a pop same cycle: push SHALL be accepted, occupancy unchanged, overflow unchanged.
REQ-020 Push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged.
REQ-021 overflow SHALL remain 1 until rst.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter SHALL range 0..FIFO_DEPTH.

Reset
REQ-023 With rst=1 at a rising edge: counter -> C0, stored nibbles -> 0, FIFO emptied, overflow -> 0.
REQ-024 Outputs after reset: w=0, w_sum=0, w_valid=0, overflow=0.
REQ-025 Reset mid-word SHALL discard partial nibbles; reset SHALL override a same-cycle push or pop.
REQ-026 Inputs SHALL be ignored during rst=1, including y_is_valid=1.

Configuration
REQ-027 Macro Y_PACKER_SUM_EN defined: w_sum computed, stored per FIFO entry, and driven as in REQ-015.
REQ-028 Y_PACKER_SUM_EN undefined: no sum logic or storage; w_sum port SHALL remain and be tied to 0; all other behaviour identical.

Verification
REQ-029 Reset, then y=5 with y_is_valid=1 for 4 cycles, w_ready=1 -> next cycle w=0x5555, w_sum=20, w_valid=1 for exactly one cycle.
REQ-030 y=1,2,3,4 with y_is_valid=0 gaps of 2 cycles between -> w=0x4321, w_sum=10, w_valid rises one cycle after the 4th nibble only.
REQ-031 w_ready=0, 12 consecutive valid nibbles 0x1..0xC, FIFO_DEPTH=2 -> words 0x4321, 0x8765 held, 0xCBA9 dropped, overflow=1; then w_ready=1 -> 0x4321 then 0x8765, then w_valid=0, overflow stays 1.
REQ-032 FIFO full, w_ready=1 in same cycle as 4th nibble of third word -> no drop, overflow=0, three words delivered in order.
REQ-033 Two nibbles 0x3,0x3 then rst for 1 cycle, then four nibbles 0xF -> w=0xFFFF, w_sum=60; no word containing 0x3 ever appears.
REQ-034 Build without Y_PACKER_SUM_EN, rerun REQ-029 -> w=0x5555, w_sum=0.
